// File: rtl/pwm_bank_pkg.sv
// Shared types for the PWM bank: alignment mode and counter direction.
// Imported by the top and the per-channel slice.
package pwm_bank_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: staged duty, live (shadow) duty and a registered comparator
// against the shared period counter.
module pwm_bank_channel #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic             load_stage,
    input  logic             load_shadow,
    output logic             pwm
);

    logic [WIDTH-1:0] stage_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic             pwm_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg  <= '0;
            shadow_reg <= '0;
            pwm_reg    <= 1'b0;
        end else begin
            if (load_stage) begin
                stage_reg <= duty;
            end
            if (load_shadow) begin
                shadow_reg <= stage_reg;
            end
            // The comparison uses the duty that is live for this cnt, so a
            // shadow load on the wrap edge only affects the next period.
            pwm_reg <= gate && (shadow_reg > cnt);
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator sharing one period counter; period, mode and
// duties are staged through a req/ready/ack handshake and go live at a wrap.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int               WIDTH      = 11,
    parameter int               CHANNELS   = 4,
    parameter logic [WIDTH-1:0] PERIOD_RST = {WIDTH{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      center_mode,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      update_req,
    output logic                      update_ready,
    output logic                      update_ack,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      pwm_sd
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_reg,  cnt_next;
    dir_t             dir_reg,  dir_next;
    logic             idle_reg, idle_next;

    logic [WIDTH-1:0] period_reg;
    logic [WIDTH-1:0] period_stage_reg;
    mode_t            mode_reg;
    mode_t            mode_stage_reg;
    logic             pending_reg;
    logic             ack_reg;
    logic             period_start_reg;
    logic             sd_reg;

    logic             boundary;
    logic             accept;
    logic             apply;
    logic             pwm_gate;

    // Counter/direction state register. idle_reg marks a counter held at 0
    // (after reset or while disabled); leaving idle is treated as a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            dir_reg  <= DIR_UP;
            idle_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_next;
            dir_reg  <= dir_next;
            idle_reg <= idle_next;
        end
    end

    always_comb begin
        cnt_next  = cnt_reg;
        dir_next  = dir_reg;
        idle_next = idle_reg;
        if (!enable) begin
            cnt_next  = '0;
            dir_next  = DIR_UP;
            idle_next = 1'b1;
        end else if (idle_reg) begin
            cnt_next  = '0;
            dir_next  = DIR_UP;
            idle_next = 1'b0;
        end else if (period_reg == '0) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (mode_reg == MODE_EDGE) begin
            dir_next = DIR_UP;
            cnt_next = (cnt_reg >= period_reg) ? '0 : cnt_reg + ONE;
        end else if (dir_reg == DIR_UP) begin
            if (cnt_reg >= period_reg) begin
                // P==1 has no down leg: 0,1,0,1...
                if (period_reg == ONE) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = period_reg - ONE;
                    dir_next = DIR_DOWN;
                end
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end else begin
            if (cnt_reg <= ONE) begin
                cnt_next = '0;
                dir_next = DIR_UP;
            end else begin
                cnt_next = cnt_reg - ONE;
            end
        end
    end

    assign boundary = enable && (cnt_next == '0) && (dir_next == DIR_UP);
    assign accept   = update_req && !pending_reg;
    assign apply    = boundary && pending_reg;
    assign pwm_gate = enable && !idle_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_reg       <= PERIOD_RST;
            period_stage_reg <= PERIOD_RST;
            mode_reg         <= MODE_EDGE;
            mode_stage_reg   <= MODE_EDGE;
            pending_reg      <= 1'b0;
            ack_reg          <= 1'b0;
            period_start_reg <= 1'b0;
            sd_reg           <= 1'b0;
        end else begin
            if (accept) begin
                period_stage_reg <= period_in;
                mode_stage_reg   <= mode_t'(center_mode);
            end
            if (apply) begin
                period_reg <= period_stage_reg;
                mode_reg   <= mode_stage_reg;
            end
            // accept needs !pending and apply needs pending, so they never collide.
            pending_reg      <= accept | (pending_reg & ~apply);
            ack_reg          <= apply;
            period_start_reg <= boundary;
            sd_reg           <= enable;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            pwm_bank_channel #(
                .WIDTH(WIDTH)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .gate       (pwm_gate),
                .cnt        (cnt_reg),
                .duty       (duty_in[gi*WIDTH +: WIDTH]),
                .load_stage (accept),
                .load_shadow(apply),
                .pwm        (pwm_out[gi])
            );
        end
    endgenerate

    assign update_ready = !pending_reg;
    assign update_ack   = ack_reg;
    assign period_start = period_start_reg;
    assign pwm_sd       = sd_reg;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank (WIDTH=4, CHANNELS=2): directed table, corner sequences
// and a randomized run against a period-sequence reference model.
module tb_pwm_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       center_mode = 1'b0;
    logic [3:0] period_in = '0;
    logic [7:0] duty_in = '0;
    logic       update_req = 1'b0;
    logic       update_ready;
    logic       update_ack;
    logic       period_start;
    logic [1:0] pwm_out;
    logic       pwm_sd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_bank #(
        .WIDTH(4),
        .CHANNELS(2),
        .PERIOD_RST(4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .center_mode (center_mode),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .update_req  (update_req),
        .update_ready(update_ready),
        .update_ack  (update_ack),
        .period_start(period_start),
        .pwm_out     (pwm_out),
        .pwm_sd      (pwm_sd)
    );

    typedef struct {
        logic center;
        int   per;
        int   d0;
        int   d1;
        int   exp_len;
        int   exp_h0;
        int   exp_h1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Reference model: the counter walks a list of values built from P and mode.
    int   seq[$];
    int   pos;
    bit   m_idle;
    int   live_p, st_p;
    bit   live_c, st_c;
    int   live_d[2];
    int   st_d[2];
    bit   pend;
    logic [1:0] m_pwm;
    logic m_sd, m_ack, m_ps;

    task automatic build_seq();
        seq.delete();
        for (int v = 0; v <= live_p; v++) seq.push_back(v);
        if (live_c) for (int v = live_p - 1; v >= 1; v--) seq.push_back(v);
    endtask

    task automatic model_reset();
        m_idle = 1; pos = 0; live_p = 15; st_p = 15; live_c = 0; st_c = 0;
        live_d[0] = 0; live_d[1] = 0; st_d[0] = 0; st_d[1] = 0; pend = 0;
        m_pwm = '0; m_sd = 0; m_ack = 0; m_ps = 0;
        build_seq();
    endtask

    task automatic model_step();
        int  c;
        bit  bnd, acc;
        c = m_idle ? 0 : seq[pos];
        for (int ch = 0; ch < 2; ch++) m_pwm[ch] = enable && !m_idle && (live_d[ch] > c);
        m_sd = enable;
        acc = update_req && !pend;
        bnd = 0;
        if (!enable) begin
            m_idle = 1;
        end else if (m_idle) begin
            m_idle = 0; pos = 0; bnd = 1;
        end else begin
            pos++;
            if (pos >= seq.size()) begin pos = 0; bnd = 1; end
        end
        m_ps = bnd;
        m_ack = bnd && pend;
        if (m_ack) begin
            live_p = st_p; live_c = st_c; live_d[0] = st_d[0]; live_d[1] = st_d[1];
            pend = 0; build_seq(); pos = 0;
        end
        if (acc) begin
            st_p = int'(period_in); st_c = center_mode;
            st_d[0] = int'(duty_in[3:0]); st_d[1] = int'(duty_in[7:4]);
            pend = 1;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic stage_update(input logic c, input int p, input int d0, input int d1);
        int n = 0;
        center_mode = c;
        period_in = p[3:0];
        duty_in = {d1[3:0], d0[3:0]};
        while (!update_ready && n < 200) begin @(negedge clk); n++; end
        if (!update_ready) check("ready_timeout", 0, 1);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
    endtask

    // Returns at the negedge of the cycle where update_ack is high (cnt==0).
    task automatic wait_ack();
        int n = 0;
        do begin @(negedge clk); n++; end while (!update_ack && n < 200);
        if (!update_ack) check("ack_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, plen, k, n;

        vecs[0] = '{1'b0,  9,  3,  0, 10,  3,  0};
        vecs[1] = '{1'b0,  9, 10, 15, 10, 10, 10};
        vecs[2] = '{1'b0,  9,  0,  9, 10,  0,  9};
        vecs[3] = '{1'b1,  8,  4,  9, 16,  7, 16};
        vecs[4] = '{1'b1,  1,  1,  0,  2,  1,  0};
        vecs[5] = '{1'b0,  0,  1,  0,  1,  1,  0};
        vecs[6] = '{1'b0, 15, 15, 14, 16, 15, 14};
        vecs[7] = '{1'b1,  3,  2,  3,  6,  3,  5};

        // Reset, released with enable low
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pwm", pwm_out, 2'b00);
        check("reset_sd", pwm_sd, 1'b0);
        check("reset_ready", update_ready, 1'b1);
        check("reset_ack", update_ack, 1'b0);
        repeat (3) @(negedge clk);
        check("disabled_outs", {pwm_out, pwm_sd, period_start}, 4'b0000);

        // Directed table: stage, wait for it to go live, measure one period
        enable = 1'b1;
        for (int v = 0; v < 8; v++) begin
            stage_update(vecs[v].center, vecs[v].per, vecs[v].d0, vecs[v].d1);
            wait_ack();
            check($sformatf("v%0d_ack_at_start", v), period_start, 1'b1);
            h0 = 0; h1 = 0; plen = 0;
            for (int kk = 1; kk <= vecs[v].exp_len; kk++) begin
                @(negedge clk);
                h0 += int'(pwm_out[0]);
                h1 += int'(pwm_out[1]);
                if (period_start && plen == 0) plen = kk;
            end
            check($sformatf("v%0d_period", v), plen, vecs[v].exp_len);
            check($sformatf("v%0d_high_ch0", v), h0, vecs[v].exp_h0);
            check($sformatf("v%0d_high_ch1", v), h1, vecs[v].exp_h1);
        end

        // Mid-period request: current period unchanged, ack at wrap, next period new
        stage_update(1'b0, 9, 3, 0);
        wait_ack();
        h0 = 0;
        for (int kk = 1; kk <= 10; kk++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            if (kk == 4) begin duty_in = {4'd0, 4'd7}; update_req = 1'b1; end
            if (kk == 5) begin update_req = 1'b0; check("mid_ready_low", update_ready, 1'b0); end
            if (kk == 9) check("mid_still_pending", {update_ready, update_ack}, 2'b00);
            if (kk == 10) check("mid_ack_at_wrap", {update_ack, period_start}, 2'b11);
        end
        check("mid_old_period_high", h0, 3);
        h0 = 0;
        for (int kk = 1; kk <= 10; kk++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
        end
        check("mid_new_period_high", h0, 7);

        // Reset with an update pending: staged duty must be discarded
        stage_update(1'b0, 9, 3, 0);
        wait_ack();
        for (int kk = 1; kk <= 5; kk++) begin
            @(negedge clk);
            if (kk == 2) begin duty_in = {4'd0, 4'd5}; update_req = 1'b1; end
            if (kk == 3) update_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_async_outs", {pwm_out, pwm_sd, update_ack, period_start, update_ready}, 6'b000001);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!period_start && n < 100);
        check("rst_first_start_seen", period_start, 1'b1);
        h0 = 0; k = 0;
        do begin
            @(negedge clk);
            k++;
            if (pwm_out != 2'b00) h0++;
        end while (!period_start && k < 100);
        check("rst_default_period", k, 16);
        check("rst_no_stale_duty", h0, 0);

        // Randomized run against the reference model
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            check($sformatf("rand_%0d", i),
                  {pwm_out, pwm_sd, update_ack, period_start, update_ready},
                  {m_pwm, m_sd, m_ack, m_ps, !pend});
            enable      = ($urandom_range(0, 19) != 0);
            update_req  = ($urandom_range(0, 3) == 0);
            center_mode = 1'($urandom_range(0, 1));
            period_in   = 4'($urandom_range(0, 7));
            duty_in     = 8'($urandom_range(0, 255));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
